// File: rtl/cl_pkg.sv
// Shared Camera Link package: count widths common with the capture block,
// transmit FSM state encoding, line geometry payload and LFSR constants.
package cl_pkg;

  localparam int unsigned N_FRAME_SIZE = 20;
  localparam int unsigned N_LINE_SIZE  = 12;
  localparam int unsigned N_CLK_SIZE   = 10;
  localparam int unsigned N_PORTS      = 10;

  // Fibonacci taps 32,22,2,1 expressed as bit positions 31,21,1,0.
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  localparam logic [31:0] LFSR_SEED = 32'h0000_0001;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FRONT  = 3'd1,
    LINE   = 3'd2,
    HBLANK = 3'd3,
    VBLANK = 3'd4,
    DONE   = 3'd5
  } state_t;

  // Per-command line geometry held for the whole run.
  typedef struct packed {
    logic [N_LINE_SIZE-1:0] lines;
    logic [N_CLK_SIZE-1:0]  clks;
  } geom_t;

  // One shift of the Fibonacci LFSR; feedback enters at bit 0.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {s[30:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/cl_tx_sim_if.sv
// Command channel of the Camera Link source simulator.
//   master: PC message path (drives command and stop, sees cmd_ready)
//   slave : cl_tx_sim
interface cl_tx_sim_if;
  import cl_pkg::*;

  logic                    cmd_valid;
  logic                    cmd_ready;
  logic [N_FRAME_SIZE-1:0] cmd_frames;
  logic [N_LINE_SIZE-1:0]  cmd_lines;
  logic [N_CLK_SIZE-1:0]   cmd_clks;
  logic                    stop;

  modport master (
    output cmd_valid, cmd_frames, cmd_lines, cmd_clks, stop,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_frames, cmd_lines, cmd_clks, stop,
    output cmd_ready
  );

endinterface

// File: rtl/cl_tx_pattern.sv
// Pixel data generator for cl_tx_sim. Inputs describe the NEXT cycle so the
// port bytes land in registers aligned with the registered cl_lval.
//   cl_clk, reset : clock, async active-high reset
//   lval          : cl_lval value for the next cycle
//   frame_start   : next cycle is the first FRONT cycle of a frame
//   pix           : pixel index within the line for the next cycle
//   ports         : ten registered port bytes (index 0 = port a)
// Build option CL_TX_LFSR_EN selects the LFSR pattern; default is the counter.
module cl_tx_pattern
  import cl_pkg::*;
(
  input  logic                       cl_clk,
  input  logic                       reset,
  input  logic                       lval,
  input  logic                       frame_start,
  input  logic [N_CLK_SIZE-1:0]      pix,
  output logic [N_PORTS-1:0][7:0]    ports
);

  logic [N_PORTS-1:0][7:0] ports_nxt;

`ifdef CL_TX_LFSR_EN
  logic [31:0]           lfsr_q;
  logic [N_CLK_SIZE-1:0] unused_pix;

  assign unused_pix = pix;

  // Register holds the value shown on the next cl_lval cycle.
  always_ff @(posedge cl_clk or posedge reset) begin
    if (reset) begin
      lfsr_q <= LFSR_SEED;
    end else if (frame_start) begin
      lfsr_q <= LFSR_SEED;
    end else if (lval) begin
      lfsr_q <= lfsr_next(lfsr_q);
    end
  end

  always_comb begin
    ports_nxt = '0;
    for (int k = 0; k < N_PORTS; k++) begin
      ports_nxt[k] = lval ? (lfsr_q[8*(k%4) +: 8] ^ 8'(k)) : 8'h00;
    end
  end
`else
  logic [N_CLK_SIZE-8:0] unused_bits;

  assign unused_bits = {frame_start, pix[N_CLK_SIZE-1:8]};

  always_comb begin
    ports_nxt = '0;
    for (int k = 0; k < N_PORTS; k++) begin
      ports_nxt[k] = lval ? (pix[7:0] + 8'(k)) : 8'h00;
    end
  end
`endif

  always_ff @(posedge cl_clk or posedge reset) begin
    if (reset) begin
      ports <= '0;
    end else begin
      ports <= ports_nxt;
    end
  end

endmodule

// File: rtl/cl_tx_sim.sv
// Camera Link source simulator: on a command generates a programmable number
// of frames (cl_fval / cl_lval / ten 8-bit ports) on cl_clk.
//   cl_clk, reset      : clock, async active-high reset
//   cmd (slave)        : cmd_valid/cmd_ready handshake, frames/lines/clks, stop
//   cl_fval, cl_lval   : frame / line valid
//   cl_port_a..j       : pixel data, 0 while cl_lval is low
//   busy, done         : not idle / one-cycle pulse on return to idle
//   frames_left        : frames not yet started
// Build option CL_TX_LFSR_EN selects LFSR pixel data (see cl_tx_pattern).
module cl_tx_sim
  import cl_pkg::*;
#(
  parameter int unsigned FRONT_PORCH = 4,
  parameter int unsigned H_BLANK     = 8,
  parameter int unsigned V_BLANK     = 16
) (
  input  logic                    cl_clk,
  input  logic                    reset,
  cl_tx_sim_if.slave              cmd,
  output logic                    cl_fval,
  output logic                    cl_lval,
  output logic [7:0]              cl_port_a,
  output logic [7:0]              cl_port_b,
  output logic [7:0]              cl_port_c,
  output logic [7:0]              cl_port_d,
  output logic [7:0]              cl_port_e,
  output logic [7:0]              cl_port_f,
  output logic [7:0]              cl_port_g,
  output logic [7:0]              cl_port_h,
  output logic [7:0]              cl_port_i,
  output logic [7:0]              cl_port_j,
  output logic                    busy,
  output logic                    done,
  output logic [N_FRAME_SIZE-1:0] frames_left
);

  localparam int unsigned T_MAX =
    (FRONT_PORCH > H_BLANK) ? ((FRONT_PORCH > V_BLANK) ? FRONT_PORCH : V_BLANK)
                            : ((H_BLANK > V_BLANK) ? H_BLANK : V_BLANK);
  localparam int unsigned TMR_W = $clog2(T_MAX + 1);

  state_t                  state_q, state_nxt;
  logic [TMR_W-1:0]        tmr_q, tmr_nxt;
  logic [N_CLK_SIZE-1:0]   pix_q, pix_nxt;
  logic [N_LINE_SIZE-1:0]  line_q, line_nxt;
  logic [N_FRAME_SIZE-1:0] frames_q, frames_nxt;
  geom_t                   geom_q, geom_nxt;
  logic                    stop_q, stop_nxt;
  logic                    fval_q, lval_q, busy_q, done_q, ready_q;
  logic                    frame_start;
  logic [N_PORTS-1:0][7:0] ports;

  // State and counter registers.
  always_ff @(posedge cl_clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      tmr_q    <= '0;
      pix_q    <= '0;
      line_q   <= '0;
      frames_q <= '0;
      geom_q   <= '0;
      stop_q   <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      tmr_q    <= tmr_nxt;
      pix_q    <= pix_nxt;
      line_q   <= line_nxt;
      frames_q <= frames_nxt;
      geom_q   <= geom_nxt;
      stop_q   <= stop_nxt;
    end
  end

  // Next-state and counter logic; timer restarts at 0 on every state change.
  always_comb begin
    state_nxt  = state_q;
    tmr_nxt    = '0;
    pix_nxt    = '0;
    line_nxt   = line_q;
    frames_nxt = frames_q;
    geom_nxt   = geom_q;
    stop_nxt   = stop_q | cmd.stop;

    unique case (state_q)
      IDLE: begin
        stop_nxt = 1'b0;
        line_nxt = '0;
        if (cmd.cmd_valid) begin
          geom_nxt.lines = cmd.cmd_lines;
          geom_nxt.clks  = cmd.cmd_clks;
          if ((cmd.cmd_frames == '0) || (cmd.cmd_lines == '0) || (cmd.cmd_clks == '0)) begin
            state_nxt  = DONE;
            frames_nxt = cmd.cmd_frames;
          end else begin
            state_nxt  = FRONT;
            frames_nxt = cmd.cmd_frames - N_FRAME_SIZE'(1);
          end
        end
      end

      FRONT: begin
        if (tmr_q == TMR_W'(FRONT_PORCH - 1)) begin
          state_nxt = LINE;
        end else begin
          tmr_nxt = tmr_q + TMR_W'(1);
        end
      end

      LINE: begin
        if (pix_q == geom_q.clks - N_CLK_SIZE'(1)) begin
          if (line_q == geom_q.lines - N_LINE_SIZE'(1)) begin
            state_nxt = VBLANK;
            line_nxt  = '0;
          end else begin
            state_nxt = HBLANK;
            line_nxt  = line_q + N_LINE_SIZE'(1);
          end
        end else begin
          pix_nxt = pix_q + N_CLK_SIZE'(1);
        end
      end

      HBLANK: begin
        if (tmr_q == TMR_W'(H_BLANK - 1)) begin
          state_nxt = LINE;
        end else begin
          tmr_nxt = tmr_q + TMR_W'(1);
        end
      end

      // A latched stop only ends the run here, so frames are never cut short.
      VBLANK: begin
        if (tmr_q == TMR_W'(V_BLANK - 1)) begin
          if ((frames_q == '0) || stop_q) begin
            state_nxt = DONE;
          end else begin
            state_nxt  = FRONT;
            frames_nxt = frames_q - N_FRAME_SIZE'(1);
          end
        end else begin
          tmr_nxt = tmr_q + TMR_W'(1);
        end
      end

      DONE: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign frame_start = (state_nxt == FRONT) && (state_q != FRONT);

  // Outputs are registered from the next state so they align with it.
  always_ff @(posedge cl_clk or posedge reset) begin
    if (reset) begin
      fval_q  <= 1'b0;
      lval_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      fval_q  <= (state_nxt == FRONT) || (state_nxt == LINE) || (state_nxt == HBLANK);
      lval_q  <= (state_nxt == LINE);
      busy_q  <= (state_nxt != IDLE);
      done_q  <= (state_nxt == DONE);
      ready_q <= (state_nxt == IDLE);
    end
  end

  cl_tx_pattern u_pattern (
    .cl_clk      (cl_clk),
    .reset       (reset),
    .lval        (state_nxt == LINE),
    .frame_start (frame_start),
    .pix         (pix_nxt),
    .ports       (ports)
  );

  assign cmd.cmd_ready = ready_q;
  assign cl_fval       = fval_q;
  assign cl_lval       = lval_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign frames_left   = frames_q;
  assign cl_port_a     = ports[0];
  assign cl_port_b     = ports[1];
  assign cl_port_c     = ports[2];
  assign cl_port_d     = ports[3];
  assign cl_port_e     = ports[4];
  assign cl_port_f     = ports[5];
  assign cl_port_g     = ports[6];
  assign cl_port_h     = ports[7];
  assign cl_port_i     = ports[8];
  assign cl_port_j     = ports[9];

endmodule

// File: tb/tb_cl_tx_sim.sv
// Scoreboard bench for cl_tx_sim: each command pushes its expected per-cycle
// output trace (derived from the frame timing rules) into a queue; a monitor
// pops and compares every cycle the DUT is active.
module tb_cl_tx_sim;

  localparam int FP = 4;
  localparam int HB = 8;
  localparam int VB = 16;

  typedef struct packed {
    logic        fval;
    logic        lval;
    logic        busy;
    logic        done;
    logic        ready;
    logic [19:0] fl;
    logic [79:0] ports;
  } rec_t;

  logic cl_clk = 1'b0;
  logic reset  = 1'b1;
  logic cl_fval, cl_lval, busy, done;
  logic [7:0] cl_port_a, cl_port_b, cl_port_c, cl_port_d, cl_port_e;
  logic [7:0] cl_port_f, cl_port_g, cl_port_h, cl_port_i, cl_port_j;
  logic [19:0] frames_left;

  int n_checks = 0;
  int n_fail   = 0;
  rec_t exp_q[$];

  cl_tx_sim_if cmd_if ();

  cl_tx_sim #(.FRONT_PORCH(FP), .H_BLANK(HB), .V_BLANK(VB)) dut (
    .cl_clk      (cl_clk),
    .reset       (reset),
    .cmd         (cmd_if),
    .cl_fval     (cl_fval),
    .cl_lval     (cl_lval),
    .cl_port_a   (cl_port_a),
    .cl_port_b   (cl_port_b),
    .cl_port_c   (cl_port_c),
    .cl_port_d   (cl_port_d),
    .cl_port_e   (cl_port_e),
    .cl_port_f   (cl_port_f),
    .cl_port_g   (cl_port_g),
    .cl_port_h   (cl_port_h),
    .cl_port_i   (cl_port_i),
    .cl_port_j   (cl_port_j),
    .busy        (busy),
    .done        (done),
    .frames_left (frames_left)
  );

  always #5 cl_clk = ~cl_clk;

  function automatic rec_t sample();
    rec_t r;
    r.fval  = cl_fval;
    r.lval  = cl_lval;
    r.busy  = busy;
    r.done  = done;
    r.ready = cmd_if.cmd_ready;
    r.fl    = frames_left;
    r.ports = {cl_port_j, cl_port_i, cl_port_h, cl_port_g, cl_port_f,
               cl_port_e, cl_port_d, cl_port_c, cl_port_b, cl_port_a};
    return r;
  endfunction

  task automatic compare(input string name, input rec_t act, input rec_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got fval=%0b lval=%0b busy=%0b done=%0b ready=%0b fl=%0d ports=%h ; expected fval=%0b lval=%0b busy=%0b done=%0b ready=%0b fl=%0d ports=%h",
               name, $time, act.fval, act.lval, act.busy, act.done, act.ready, act.fl, act.ports,
               exp.fval, exp.lval, exp.busy, exp.done, exp.ready, exp.fl, exp.ports);
    end
  endtask

  // Reference model: expected trace from cycle T+1 after accept, one entry per cycle.
  task automatic push_cmd(input int f, input int l, input int c, input int stop_at);
    rec_t r;
    int p, nrun, q, fl_end;
`ifdef CL_TX_LFSR_EN
    logic [31:0] s;
`endif
    if (f == 0 || l == 0 || c == 0) begin
      r = '0; r.busy = 1'b1; r.done = 1'b1; r.fl = 20'(f);
      exp_q.push_back(r);
      fl_end = f;
    end else begin
      p    = FP + l * c + (l - 1) * HB + VB;
      nrun = f;
      if (stop_at >= 0 && (stop_at / p) + 1 < nrun) nrun = (stop_at / p) + 1;
      for (int i = 0; i < nrun; i++) begin
`ifdef CL_TX_LFSR_EN
        s = 32'h1;
`endif
        for (int o = 0; o < p; o++) begin
          r = '0; r.busy = 1'b1; r.fl = 20'(f - 1 - i);
          r.fval = (o < p - VB);
          if (o >= FP && o < p - VB) begin
            q = (o - FP) % (c + HB);
            if (q < c) begin
              r.lval = 1'b1;
              for (int k = 0; k < 10; k++) begin
`ifdef CL_TX_LFSR_EN
                r.ports[8*k +: 8] = s[8*(k%4) +: 8] ^ 8'(k);
`else
                r.ports[8*k +: 8] = 8'((q + k) % 256);
`endif
              end
`ifdef CL_TX_LFSR_EN
              s = {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
`endif
            end
          end
          exp_q.push_back(r);
        end
      end
      fl_end = f - nrun;
      r = '0; r.busy = 1'b1; r.done = 1'b1; r.fl = 20'(fl_end);
      exp_q.push_back(r);
    end
    r = '0; r.ready = 1'b1; r.fl = 20'(fl_end);
    exp_q.push_back(r);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || cmd_if.cmd_ready !== 1'b1) && n < 5000) begin
      @(negedge cl_clk);
      n++;
    end
    if (n >= 5000) begin
      n_checks++;
      n_fail++;
      $display("FAIL wait_idle: timeout, queue=%0d ready=%0b, required queue=0 ready=1",
               exp_q.size(), cmd_if.cmd_ready);
      exp_q.delete();
    end
  endtask

  task automatic issue(input int f, input int l, input int c, input int stop_at);
    wait_idle();
    @(negedge cl_clk);
    cmd_if.cmd_valid  = 1'b1;
    cmd_if.cmd_frames = 20'(f);
    cmd_if.cmd_lines  = 12'(l);
    cmd_if.cmd_clks   = 10'(c);
    @(posedge cl_clk);
    #1;
    cmd_if.cmd_valid = 1'b0;
    push_cmd(f, l, c, stop_at);
    if (stop_at >= 0) begin
      repeat (stop_at) @(posedge cl_clk);
      #1 cmd_if.stop = 1'b1;
      @(posedge cl_clk);
      #1 cmd_if.stop = 1'b0;
    end
  endtask

  // Monitor: compare against the scoreboard every active cycle.
  initial begin
    rec_t act, exp;
    forever begin
      @(negedge cl_clk);
      if (!reset) begin
        act = sample();
        if (exp_q.size() > 0) begin
          exp = exp_q.pop_front();
          compare("trace", act, exp);
        end else if (busy || done || cl_fval || cl_lval || cmd_if.cmd_ready !== 1'b1) begin
          n_checks++;
          n_fail++;
          $display("FAIL idle_activity @%0t: busy=%0b done=%0b fval=%0b lval=%0b ready=%0b, required 0 0 0 0 1",
                   $time, busy, done, cl_fval, cl_lval, cmd_if.cmd_ready);
        end
      end
    end
  end

  initial begin
    rec_t idle_exp;
    int f, l, c;
    cmd_if.cmd_valid  = 1'b0;
    cmd_if.cmd_frames = '0;
    cmd_if.cmd_lines  = '0;
    cmd_if.cmd_clks   = '0;
    cmd_if.stop       = 1'b0;
    idle_exp = '0;
    idle_exp.ready = 1'b1;

    #12 compare("reset_state", sample(), idle_exp);
    #1 reset = 1'b0;

    issue(1, 2, 4, -1);           // directed frame: 20 cycles fval, ports c = 2..5
    issue(3, 1, 1, -1);           // frames_left 2,1,0
    issue(0, 3, 3, -1);           // degenerate frames
    issue(2, 2, 0, -1);           // degenerate clks
    issue(5, 2, 4, 36 + FP + 1);  // stop mid-line in frame 2

    // cmd_valid while busy must be ignored
    issue(2, 3, 5, -1);
    repeat (3) @(negedge cl_clk);
    cmd_if.cmd_valid  = 1'b1;
    cmd_if.cmd_frames = 20'd7;
    cmd_if.cmd_lines  = 12'd1;
    cmd_if.cmd_clks   = 10'd2;
    repeat (4) @(negedge cl_clk);
    cmd_if.cmd_valid = 1'b0;

    // Asynchronous reset in the middle of a line
    issue(2, 3, 6, -1);
    repeat (FP + 3) @(posedge cl_clk);
    #2 reset = 1'b1;
    exp_q.delete();
    #1 compare("reset_mid_line", sample(), idle_exp);
    @(negedge cl_clk);
    #1 reset = 1'b0;
    issue(1, 2, 3, -1);

    for (int i = 0; i < 12; i++) begin
      f = ($urandom_range(7, 0) == 0) ? 0 : int'($urandom_range(3, 1));
      l = int'($urandom_range(4, 1));
      c = ($urandom_range(9, 0) == 0) ? 0 : int'($urandom_range(6, 1));
      issue(f, l, c, -1);
    end

    wait_idle();
    repeat (4) @(negedge cl_clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
